// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window sequencer.
package sobel_pkg;

    localparam int ADDR_W = 8;
    localparam int PIX_W  = 8;
    localparam int WIN_N  = 9;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CALC,
        WR_REQ,
        WR_WAIT,
        FIN
    } state_e;

    // Slot k holds window pixel (k / 3, k % 3); slot 0 is top-left.
    typedef logic [PIX_W-1:0] window_t [WIN_N];

    function automatic logic [1:0] slot_row(input logic [3:0] k);
        if (k >= 4'd6) begin
            return 2'd2;
        end else if (k >= 4'd3) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    function automatic logic [1:0] slot_col(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/sobel_sequencer_if.sv
// Handshake bundle between the sequencer (master) and its memory bridge / compute core (slave).
interface sobel_sequencer_if;
    import sobel_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 read_data_done;
    logic                 write_done;
    logic [PIX_W-1:0]     data_r_o;
    logic                 start_read;
    logic                 start_write;
    logic [ADDR_W-1:0]    addr_r_mc;
    logic [ADDR_W-1:0]    addr_w_mc;
    logic [PIX_W-1:0]     data_w;
    logic [9*PIX_W-1:0]   window;
    logic                 window_valid;
    logic [PIX_W-1:0]     result;
    logic                 result_valid;
    logic                 active;
    logic                 done;

    modport master (
        input  start, busy, read_data_done, write_done, data_r_o, result, result_valid,
        output start_read, start_write, addr_r_mc, addr_w_mc, data_w, window,
               window_valid, active, done
    );

    modport slave (
        output start, busy, read_data_done, write_done, data_r_o, result, result_valid,
        input  start_read, start_write, addr_r_mc, addr_w_mc, data_w, window,
               window_valid, active, done
    );

endinterface

// File: rtl/sobel_window_buf.sv
// 3x3 pixel slot array with single-slot load and, when WINDOW_REUSE_EN is
// defined, a left shift of the columns for stepping to the next centre.
module sobel_window_buf
    import sobel_pkg::*;
(
    input  logic                clk,
    input  logic                n_rst,
    input  logic                load_i,
    input  logic [3:0]          slot_i,
    input  logic [PIX_W-1:0]    pix_i,
`ifdef WINDOW_REUSE_EN
    input  logic                shift_i,
`endif
    output logic [9*PIX_W-1:0]  window_o
);

    window_t slots_q;
    window_t slots_d;

    // Next slot contents: optional column shift, then the incoming pixel.
    always_comb begin
        slots_d = slots_q;
`ifdef WINDOW_REUSE_EN
        if (shift_i) begin
            for (int r = 0; r < 3; r++) begin
                slots_d[3*r]   = slots_q[3*r+1];
                slots_d[3*r+1] = slots_q[3*r+2];
            end
        end
`endif
        for (int k = 0; k < WIN_N; k++) begin
            if (load_i && (slot_i == 4'(k))) begin
                slots_d[k] = pix_i;
            end
        end
    end

    // Slot registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int k = 0; k < WIN_N; k++) begin
                slots_q[k] <= '0;
            end
        end else begin
            slots_q <= slots_d;
        end
    end

    // Flatten to the row-major output bus, slot k at byte k.
    always_comb begin
        window_o = '0;
        for (int k = 0; k < WIN_N; k++) begin
            window_o[k*PIX_W +: PIX_W] = slots_q[k];
        end
    end

endmodule

// File: rtl/sobel_sequencer.sv
// Frame sequencer for a 3x3 Sobel filter: fetches each interior window from
// memory, hands it to the compute core, and writes the filter result back.
// Optional build macro: WINDOW_REUSE_EN (reuse two window columns between
// horizontally adjacent centres, reading only the new column).
//
// state   | meaning
// IDLE    | waiting for start
// RD_REQ  | issue a pixel read once the bus is free
// RD_WAIT | wait for read data, store it in the window slot
// CALC    | window complete, wait for the filter result
// WR_REQ  | issue the result write once the bus is free
// WR_WAIT | wait for write completion, advance the centre
// FIN     | one-cycle frame-done pulse
module sobel_sequencer
    import sobel_pkg::*;
#(
    parameter int                IMG_W    = 8,
    parameter int                IMG_H    = 8,
    parameter logic [ADDR_W-1:0] SRC_BASE = 8'd0,
    parameter logic [ADDR_W-1:0] DST_BASE = 8'd128
)(
    input  logic             clk,
    input  logic             n_rst,
    sobel_sequencer_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] OUT_STRIDE = ADDR_W'(IMG_W - 2);

    state_e             state_q, state_d;
    // Window origin (top-left pixel), i.e. centre minus one in each axis.
    logic [ADDR_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0]  col_q, col_d;
    logic [3:0]         slot_q, slot_d;
    logic [PIX_W-1:0]   data_w_q, data_w_d;
    logic               win_valid_q, win_valid_d;
    logic               load;
    logic               last_centre;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ADDR_W-1:0]  wr_addr;
    logic [9*PIX_W-1:0] window_w;
`ifdef WINDOW_REUSE_EN
    logic               reuse_q, reuse_d;
    logic               shift;
`endif

    assign last_centre = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign rd_addr = SRC_BASE
                   + (row_q + {6'd0, slot_row(slot_q)}) * ROW_STRIDE
                   + col_q + {6'd0, slot_col(slot_q)};
    assign wr_addr = DST_BASE + row_q * OUT_STRIDE + col_q;

    sobel_window_buf u_win (
        .clk      (clk),
        .n_rst    (n_rst),
        .load_i   (load),
        .slot_i   (slot_q),
        .pix_i    (bus.data_r_o),
`ifdef WINDOW_REUSE_EN
        .shift_i  (shift),
`endif
        .window_o (window_w)
    );

    // State, counters and held output registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            slot_q      <= '0;
            data_w_q    <= '0;
            win_valid_q <= 1'b0;
`ifdef WINDOW_REUSE_EN
            reuse_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            slot_q      <= slot_d;
            data_w_q    <= data_w_d;
            win_valid_q <= win_valid_d;
`ifdef WINDOW_REUSE_EN
            reuse_q     <= reuse_d;
`endif
        end
    end

    // Next-state, counter stepping and window control.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        slot_d      = slot_q;
        data_w_d    = data_w_q;
        win_valid_d = 1'b0;
        load        = 1'b0;
`ifdef WINDOW_REUSE_EN
        reuse_d     = reuse_q;
        shift       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RD_REQ;
                    row_d   = '0;
                    col_d   = '0;
                    slot_d  = '0;
`ifdef WINDOW_REUSE_EN
                    reuse_d = 1'b0;
`endif
                end
            end
            RD_REQ: begin
                if (!bus.busy) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.read_data_done) begin
                    load = 1'b1;
                    if (slot_q == 4'd8) begin
                        state_d     = CALC;
                        win_valid_d = 1'b1;
                    end else begin
                        state_d = RD_REQ;
`ifdef WINDOW_REUSE_EN
                        // A reused window only fetches the right-hand column.
                        slot_d  = reuse_q ? (slot_q + 4'd3) : (slot_q + 4'd1);
`else
                        slot_d  = slot_q + 4'd1;
`endif
                    end
                end
            end
            CALC: begin
                if (bus.result_valid) begin
                    data_w_d = bus.result;
                    state_d  = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!bus.busy) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (bus.write_done) begin
                    if (last_centre) begin
                        state_d = FIN;
                    end else begin
                        state_d = RD_REQ;
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            row_d   = row_q + 8'd1;
                            slot_d  = '0;
`ifdef WINDOW_REUSE_EN
                            reuse_d = 1'b0;
`endif
                        end else begin
                            col_d   = col_q + 8'd1;
`ifdef WINDOW_REUSE_EN
                            shift   = 1'b1;
                            reuse_d = 1'b1;
                            slot_d  = 4'd2;
`else
                            slot_d  = '0;
`endif
                        end
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs; addresses are forced to zero outside their request phases.
    always_comb begin
        bus.start_read   = (state_q == RD_REQ) && !bus.busy;
        bus.start_write  = (state_q == WR_REQ) && !bus.busy;
        bus.addr_r_mc    = ((state_q == RD_REQ) || (state_q == RD_WAIT)) ? rd_addr : '0;
        bus.addr_w_mc    = ((state_q == WR_REQ) || (state_q == WR_WAIT)) ? wr_addr : '0;
        bus.data_w       = data_w_q;
        bus.window       = window_w;
        bus.window_valid = win_valid_q;
        bus.active       = (state_q != IDLE);
        bus.done         = (state_q == FIN);
    end

endmodule

// File: tb/tb_sobel_sequencer.sv
// Self-checking bench for sobel_sequencer on a 4x4 image: memory returns
// data = address, the compute core returns the window centre pixel.
module tb_sobel_sequencer;

    localparam int         W   = 4;
    localparam int         H   = 4;
    localparam logic [7:0] DST = 8'd128;
    localparam int         NC  = (W - 2) * (H - 2);

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    sobel_sequencer_if bus ();

    sobel_sequencer #(
        .IMG_W    (W),
        .IMG_H    (H),
        .SRC_BASE (8'd0),
        .DST_BASE (DST)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Reference model: full-frame expectations from the filter's geometry.
    logic [7:0]  exp_rd[$];
    logic [7:0]  exp_wa[$];
    logic [7:0]  exp_wd[$];
    logic [71:0] exp_win[$];

    logic [7:0] pin_rd [9] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    logic [7:0] pin_wa [4] = '{8'd128, 8'd129, 8'd130, 8'd131};
    logic [7:0] pin_wd [4] = '{8'd5, 8'd6, 8'd9, 8'd10};

    int n_checks = 0;
    int n_fail   = 0;
    int rd_idx   = 0;
    int wr_idx   = 0;
    int wv_idx   = 0;
    int done_cnt = 0;
    int tmo_cnt  = 0;
    int start_req_cnt = 0;
    int busy_mode = 0;
    bit stray_en  = 1'b0;

    function automatic void build_model();
        logic [71:0] w;
        bit reuse;
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                reuse = 1'b0;
`ifdef WINDOW_REUSE_EN
                reuse = (c != 1);
`endif
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!reuse || dc == 1) begin
                            exp_rd.push_back(8'((r + dr) * W + (c + dc)));
                        end
                    end
                end
                w = '0;
                for (int k = 0; k < 9; k++) begin
                    w[8*k +: 8] = 8'((r - 1 + k / 3) * W + (c - 1 + k % 3));
                end
                exp_win.push_back(w);
                exp_wa.push_back(8'(int'(DST) + (r - 1) * (W - 2) + (c - 1)));
                exp_wd.push_back(8'(r * W + c));
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: checks every DUT output against the model each cycle.
    initial begin : compare
        bit         rd_out, wr_out, prev_low, idle_next;
        logic [7:0] rd_out_a, wr_out_a, wr_out_d;
        int         tmo_seen;
        rd_out = 0; wr_out = 0; prev_low = 0; idle_next = 0; tmo_seen = 0;
        rd_out_a = '0; wr_out_a = '0; wr_out_d = '0;
        @(negedge clk);
        for (int i = 0; i < 9; i++) chk("model_pin_rd", 72'(exp_rd[i]), 72'(pin_rd[i]));
        for (int i = 0; i < 4; i++) begin
            chk("model_pin_wa", 72'(exp_wa[i]), 72'(pin_wa[i]));
            chk("model_pin_wd", 72'(exp_wd[i]), 72'(pin_wd[i]));
        end
`ifdef WINDOW_REUSE_EN
        chk("model_pin_count", 72'(exp_rd.size()), 72'd24);
        chk("model_pin_reuse0", 72'(exp_rd[9]), 72'd3);
        chk("model_pin_reuse1", 72'(exp_rd[10]), 72'd7);
        chk("model_pin_reuse2", 72'(exp_rd[11]), 72'd11);
`else
        chk("model_pin_count", 72'(exp_rd.size()), 72'd36);
        chk("model_pin_c2_0", 72'(exp_rd[9]), 72'd1);
        chk("model_pin_c2_2", 72'(exp_rd[11]), 72'd3);
`endif
        forever begin
            @(negedge clk);
            if (tmo_cnt != tmo_seen) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout: got no progress, expected done/read event at %0t", $time);
                tmo_seen = tmo_cnt;
            end
            if (!n_rst) begin
                rd_idx = 0; wr_idx = 0; wv_idx = 0;
                rd_out = 0; wr_out = 0; idle_next = 0;
                prev_low = 1;
            end else begin
                if (prev_low) begin
                    chk("rst_active", 72'(bus.active), 72'd0);
                    chk("rst_strobes", 72'({bus.start_read, bus.start_write, bus.window_valid, bus.done}), 72'd0);
                    chk("rst_addr_data", 72'({bus.addr_r_mc, bus.addr_w_mc, bus.data_w}), 72'd0);
                    chk("rst_window", bus.window, 72'd0);
                    prev_low = 0;
                end
                chk("one_request", 72'(bus.start_read & bus.start_write), 72'd0);
                if (idle_next) begin
                    chk("idle_after_done", 72'(bus.active), 72'd0);
                    idle_next = 0;
                end
                if (rd_out) begin
                    chk("rd_addr_hold", 72'(bus.addr_r_mc), 72'(rd_out_a));
                    if (bus.read_data_done) rd_out = 0;
                end
                if (wr_out) begin
                    chk("wr_addr_hold", 72'(bus.addr_w_mc), 72'(wr_out_a));
                    chk("wr_data_hold", 72'(bus.data_w), 72'(wr_out_d));
                    if (bus.write_done) wr_out = 0;
                end
                if (bus.start_read) begin
                    chk("rd_while_busy", 72'(bus.busy), 72'd0);
                    chk("rd_active", 72'(bus.active), 72'd1);
                    if (rd_idx < exp_rd.size())
                        chk("rd_addr", 72'(bus.addr_r_mc), 72'(exp_rd[rd_idx]));
                    else
                        chk("rd_extra", 72'(rd_idx), 72'(exp_rd.size()));
                    rd_idx++;
                    rd_out = 1;
                    rd_out_a = bus.addr_r_mc;
                end
                if (bus.start_write) begin
                    chk("wr_while_busy", 72'(bus.busy), 72'd0);
                    if (wr_idx < NC) begin
                        chk("wr_addr", 72'(bus.addr_w_mc), 72'(exp_wa[wr_idx]));
                        chk("wr_data", 72'(bus.data_w), 72'(exp_wd[wr_idx]));
                    end else begin
                        chk("wr_extra", 72'(wr_idx), 72'(NC));
                    end
                    wr_idx++;
                    wr_out = 1;
                    wr_out_a = bus.addr_w_mc;
                    wr_out_d = bus.data_w;
                end
                if (bus.window_valid) begin
                    if (wv_idx < NC)
                        chk("window", bus.window, exp_win[wv_idx]);
                    else
                        chk("wv_extra", 72'(wv_idx), 72'(NC));
                    wv_idx++;
                end
                if (bus.done) begin
                    chk("done_reads", 72'(rd_idx), 72'(exp_rd.size()));
                    chk("done_writes", 72'(wr_idx), 72'(NC));
                    chk("done_windows", 72'(wv_idx), 72'(NC));
                    done_cnt++;
                    rd_idx = 0; wr_idx = 0; wv_idx = 0;
                    idle_next = 1;
                end
            end
        end
    end

    // Environment: memory bridge, compute core, busy pattern and stray strobes.
    initial begin : driver
        int         rd_cnt, wr_cnt, rv_cnt, stall, start_sent;
        logic [7:0] rd_a, rv_val, s_ra, s_b4;
        logic       s_rd, s_wr, s_wv, s_nrst;
        bit         ev;
        rd_cnt = 0; wr_cnt = 0; rv_cnt = 0; stall = 0; start_sent = 0;
        rd_a = '0; rv_val = '0;
        bus.start = 0; bus.busy = 0; bus.read_data_done = 0; bus.write_done = 0;
        bus.data_r_o = '0; bus.result = '0; bus.result_valid = 0;
        forever begin
            @(negedge clk);
            s_nrst = n_rst;
            s_rd   = bus.start_read;
            s_ra   = bus.addr_r_mc;
            s_wr   = bus.start_write;
            s_wv   = bus.window_valid;
            s_b4   = bus.window[39:32];
            @(posedge clk);
            #1;
            bus.start = 0; bus.read_data_done = 0; bus.write_done = 0; bus.result_valid = 0;
            bus.data_r_o = 8'($urandom);
            bus.result   = 8'($urandom);
            ev = 0;
            if (!s_nrst) begin
                rd_cnt = 0; wr_cnt = 0; rv_cnt = 0; stall = 0;
                bus.busy = 0;
            end else begin
                if (start_sent != start_req_cnt) begin
                    bus.start = 1;
                    start_sent = start_req_cnt;
                    ev = 1;
                end
                if (s_rd) begin rd_cnt = $urandom_range(1, 4); rd_a = s_ra; end
                if (s_wr) wr_cnt = $urandom_range(1, 4);
                if (s_wv) begin rv_cnt = $urandom_range(1, 4); rv_val = s_b4; end
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin bus.read_data_done = 1; bus.data_r_o = rd_a; ev = 1; end
                end
                if (wr_cnt > 0) begin
                    wr_cnt--;
                    if (wr_cnt == 0) begin bus.write_done = 1; ev = 1; end
                end
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin bus.result_valid = 1; bus.result = rv_val; ev = 1; end
                end
                if (stray_en && rd_cnt > 0 && $urandom_range(0, 2) == 0) begin
                    bus.start = 1;
                    bus.write_done = 1;
                    bus.result_valid = 1;
                end
                case (busy_mode)
                    1: bus.busy = ($urandom_range(0, 3) == 0);
                    2: begin
                        if (ev) stall = 6;
                        if (stall > 0) begin bus.busy = 1; stall--; end
                        else bus.busy = 0;
                    end
                    default: bus.busy = 0;
                endcase
            end
        end
    end

    task automatic run_frame(input int mode, input bit stray);
        int target;
        busy_mode = mode;
        stray_en  = stray;
        target    = done_cnt + 1;
        start_req_cnt++;
        for (int i = 0; i < 3000 && done_cnt < target; i++) @(posedge clk);
        if (done_cnt < target) tmo_cnt++;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin : main
        build_model();
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        run_frame(2, 1'b0);
        run_frame(1, 1'b1);
        run_frame(0, 1'b1);
        // Abandon a frame while the second centre's first read is outstanding.
        busy_mode = 0;
        stray_en  = 1'b0;
        start_req_cnt++;
        for (int i = 0; i < 2000 && rd_idx < 10; i++) @(posedge clk);
        if (rd_idx < 10) tmo_cnt++;
        #1 n_rst = 1'b0;
        @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_frame(0, 1'b0);
        for (int i = 0; i < 4; i++) run_frame($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_sequencer.md
SOBEL_SEQUENCER -- requirements
Module: sobel_sequencer

Interface
REQ-001 Parameters: IMG_W, default 8, image width in pixels; IMG_H, default 8, image height; SRC_BASE, default 8'd0, input image base address; DST_BASE, default 8'd128, output image base address.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 n_rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle pulse that begins processing one frame.
REQ-005 busy  input  1  memory busy; no new request is issued while high.
REQ-006 read_data_done / write_done  input  1 each  memory read-complete / write-complete strobes.
REQ-007 data_r_o  input  8  read pixel, valid in the read_data_done cycle.
REQ-008 start_read / start_write  output  1 each  one-cycle request pulses to the read/write bridge.
REQ-009 addr_r_mc / addr_w_mc  output  8 each  request addresses, held stable from the request pulse until its done strobe.
REQ-010 data_w  output  8  write data, held stable with addr_w_mc.
REQ-011 window  output  72  3x3 pixel window, row-major; byte k = bits [8k+7:8k], k=0 is top-left.
REQ-012 window_valid  output  1  one-cycle pulse when the window is complete.
REQ-013 result / result_valid  input  8 / 1  filter output and its strobe from the compute core.
REQ-014 active / done  output  1 each  frame in progress / one-cycle frame-complete pulse.

Function
REQ-015 FSM states: IDLE, RD_REQ, RD_WAIT, CALC, WR_REQ, WR_WAIT, FIN.
REQ-016 IDLE->RD_REQ on start; start is ignored in every other state.
REQ-017 RD_REQ: pulse start_read only in a cycle with busy=0, then go to RD_WAIT; while busy=1, stay with no pulse.
REQ-018 RD_WAIT: on read_data_done, latch data_r_o into the current window slot.
REQ-018a RD_WAIT exit: RD_REQ if window reads remain, else CALC with window_valid pulsed on entry.
REQ-019 Window pixel (r,c) read address = SRC_BASE + r*IMG_W + c, truncated to 8 bits.
REQ-019a Window for centre (R,C) spans rows R-1..R+1 and columns C-1..C+1.
REQ-020 Centres cover the interior only, R in 1..IMG_H-2 and C in 1..IMG_W-2, in raster order: C increments, wraps to 1 at the row end, then R increments.
REQ-021 CALC: wait for result_valid, latch result into data_w, go to WR_REQ.
REQ-022 WR_REQ: addr_w_mc = DST_BASE + (R-1)*(IMG_W-2) + (C-1); pulse start_write only when busy=0.
REQ-023 WR_WAIT: on write_done, advance the centre and go to RD_REQ; after the last centre, go to FIN instead.
REQ-024 FIN: pulse done for one cycle, then go to IDLE.
REQ-025 active=1 in every state except IDLE.
REQ-026 Done/valid strobes arriving in a state that does not expect them are ignored.
REQ-027 At most one request is outstanding; start_read and start_write are never high together.

Reset
REQ-028 n_rst=0 at a clock edge forces IDLE and clears every output, window register, and the row/column counters to 0.
REQ-028a A frame in progress when reset is asserted is abandoned; no pending request is reissued.

Configuration
REQ-029 WINDOW_REUSE_EN defined: on each column advance within a row, window columns 0..1 take old columns 1..2 (shift left), and only 3 pixels are read, for column C+1, rows R-1..R+1.
REQ-029a With WINDOW_REUSE_EN, the first centre of each row still reads all 9 pixels.
REQ-030 WINDOW_REUSE_EN undefined: every centre reads all 9 pixels; the shift logic is absent.

Structure
REQ-031 Package sobel_pkg holds: the state enum, the window typedef (array of 9 bytes), ADDR_W=8, PIX_W=8.
REQ-032 Sub-module sobel_window_buf holds the 9-byte slot array and its load/shift controls; the FSM and counters stay in sobel_sequencer.

Verification
Common setup: IMG_W=4, IMG_H=4, DST_BASE=128; memory model returns data = address; compute model returns result = window byte 4.
REQ-033 Basic frame: start -> read addresses 0,1,2,4,5,6,8,9,10, then window_valid.
REQ-033a Basic frame (continued) -> writes (128,5), (129,6), (130,9), (131,10), then one done pulse.
REQ-034 Read count: without WINDOW_REUSE_EN, 36 start_read pulses per frame.
REQ-034a Read count: with WINDOW_REUSE_EN, 24 pulses per frame; the second centre reads only 3, 7, 11.
REQ-035 Stall: hold busy=1 for 5 cycles at each RD_REQ/WR_REQ -> no request pulse while busy=1, addresses stable, results as REQ-033a.
REQ-036 Mid-frame reset: assert n_rst=0 during RD_WAIT of the 2nd centre -> next cycle all outputs 0 and state IDLE.
REQ-036a After that reset, a new start reproduces REQ-033 from address 0.
REQ-037 Stray strobes: pulse start and write_done during RD_WAIT -> both ignored, sequence unchanged.
